multicycle_controller_hs: RTL

- Next-generation multicycle MIPS control FSM for the shared-memory datapath: same datapath control bus, now with a variable-latency memory handshake, a bus-timeout watchdog, JAL/SLTI decode, an illegal-opcode trap, and parametrised field widths.
- Sits between the instruction register (opcode/func) and the datapath muxes, register-file write enable, and memory strobes.
- All opcode, func and ALU_CTRL encodings come from the shared constants package.

---
 rtl/multicycle_controller_hs_pkg.sv | 58 +++++
 rtl/mc_wait_timer.sv | 39 +++
 rtl/multicycle_controller_hs.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_hs_pkg.sv
// Shared constants for the multicycle MIPS controller: opcode/func codes,
// ALU control classes, datapath mux selects and the 4-bit state encoding.
package multicycle_controller_hs_pkg;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FUNC_JR  = 6'h08;
  localparam logic [5:0] FUNC_ADD = 6'h20;
  localparam logic [5:0] FUNC_AND = 6'h24;
  localparam logic [5:0] FUNC_SLT = 6'h2A;

  // ALU control classes handed to the ALU controller
  localparam logic [1:0] ALU_CTRL_MTYPE = 2'b00;  // address / PC add
  localparam logic [1:0] ALU_CTRL_BTYPE = 2'b01;  // branch compare
  localparam logic [1:0] ALU_CTRL_RTYPE = 2'b10;  // decode from ctrl_func

  // PC source mux selects
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b01;
  localparam logic [1:0] PC_SRC_REG    = 2'b10;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b11;

  // ALU B operand mux selects
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Controller states; values are visible on the debug state port
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_BRANCH  = 4'd2,
    S_JUMP    = 4'd3,
    S_JAL     = 4'd4,
    S_JR      = 4'd5,
    S_REXEC   = 4'd6,
    S_IEXEC   = 4'd7,
    S_WB      = 4'd8,
    S_MEMADDR = 4'd9,
    S_LWREAD  = 4'd10,
    S_LWWB    = 4'd11,
    S_SWWRITE = 4'd12,
    S_TRAP    = 4'd13
  } state_t;

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait watchdog: counts enabled cycles, cleared by the owner, and
// flags the cycle on which the WAIT_LIMIT-th enabled cycle is occurring.
module mc_wait_timer #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);
  localparam int CW = 8;
  localparam logic [CW-1:0] LAST = CW'(WAIT_LIMIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear has priority so a state change always restarts the count
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds the number of earlier waits, so this is the last allowed one
  assign hit_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_controller_hs.sv
// Multicycle MIPS control FSM with memory handshake, bus watchdog and
// illegal-opcode trap. Optional retire counter: MULTICYCLE_RETIRE_CNT_EN.
module multicycle_controller_hs
  import multicycle_controller_hs_pkg::*;
#(
  parameter int OPC_W      = 6,
  parameter int FUNC_W     = 6,
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [FUNC_W-1:0] func,
  input  logic              mem_ready,
  output logic              pc_write,
  output logic              pc_write_cond,
  output logic              IR_write,
  output logic              reg_dst,
  output logic              jal_reg,
  output logic              pc_to_reg,
  output logic              mem_to_reg,
  output logic              reg_write,
  output logic              alu_src_A,
  output logic              I_or_D,
  output logic              mem_write,
  output logic              mem_read,
  output logic [1:0]        alu_src_B,
  output logic [1:0]        pc_src,
  output logic [1:0]        alu_ctrl,
  output logic [FUNC_W-1:0] ctrl_func,
  output logic              illegal,
  output logic              bus_err,
  output logic [3:0]        state,
  output logic [CNT_W-1:0]  retired
);

  state_t state_q, state_d;
  logic   wb_rtype_q, wb_rtype_d;   // remembers R-type vs immediate for S_WB
  logic   illegal_q, illegal_d;
  logic   bus_err_q, bus_err_d;
  logic   wait_en, wait_clr, wait_hit;

  // Only the three handshake states wait on memory
  assign wait_en  = ((state_q == S_FETCH) || (state_q == S_LWREAD) ||
                     (state_q == S_SWWRITE)) && !mem_ready;
  assign wait_clr = (state_d != state_q);

  mc_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_timer (
    .clk   (clk),
    .rst_n (rst),
    .clr_i (wait_clr),
    .en_i  (wait_en),
    .hit_o (wait_hit)
  );

  // Immediate ops force their ALU function; everything else forwards func
  always_comb begin
    ctrl_func = func;
    if (opcode == OPC_W'(OPC_ANDI)) begin
      ctrl_func = FUNC_W'(FUNC_AND);
    end else if (opcode == OPC_W'(OPC_ADDI)) begin
      ctrl_func = FUNC_W'(FUNC_ADD);
    end else if (opcode == OPC_W'(OPC_SLTI)) begin
      ctrl_func = FUNC_W'(FUNC_SLT);
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    state_d       = state_q;
    wb_rtype_d    = wb_rtype_q;
    illegal_d     = illegal_q;
    bus_err_d     = bus_err_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    IR_write      = 1'b0;
    reg_dst       = 1'b0;
    jal_reg       = 1'b0;
    pc_to_reg     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_A     = 1'b0;
    I_or_D        = 1'b0;
    mem_write     = 1'b0;
    mem_read      = 1'b0;
    alu_src_B     = SRCB_REG;
    pc_src        = PC_SRC_ALU;
    alu_ctrl      = ALU_CTRL_MTYPE;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_B = SRCB_FOUR;
        IR_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (wait_hit) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_B = SRCB_IMM_SH2;
        case (opcode)
          OPC_W'(OPC_BEQ), OPC_W'(OPC_BNE): state_d = S_BRANCH;
          OPC_W'(OPC_J):                    state_d = S_JUMP;
          OPC_W'(OPC_JAL):                  state_d = S_JAL;
          OPC_W'(OPC_RTYPE): begin
            wb_rtype_d = 1'b1;
            state_d    = (func == FUNC_W'(FUNC_JR)) ? S_JR : S_REXEC;
          end
          OPC_W'(OPC_LW), OPC_W'(OPC_SW):   state_d = S_MEMADDR;
          OPC_W'(OPC_ADDI), OPC_W'(OPC_ANDI), OPC_W'(OPC_SLTI): begin
            wb_rtype_d = 1'b0;
            state_d    = S_IEXEC;
          end
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_BRANCH: begin
        alu_src_A     = 1'b1;
        pc_write_cond = 1'b1;
        pc_src        = PC_SRC_BRANCH;
        alu_ctrl      = ALU_CTRL_BTYPE;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PC_SRC_JUMP;
        state_d  = S_FETCH;
      end
      S_JAL: begin
        pc_write  = 1'b1;
        pc_src    = PC_SRC_JUMP;
        reg_write = 1'b1;
        jal_reg   = 1'b1;
        pc_to_reg = 1'b1;
        state_d   = S_FETCH;
      end
      S_JR: begin
        pc_write = 1'b1;
        pc_src   = PC_SRC_REG;
        state_d  = S_FETCH;
      end
      S_REXEC: begin
        alu_src_A = 1'b1;
        alu_ctrl  = ALU_CTRL_RTYPE;
        state_d   = S_WB;
      end
      S_IEXEC: begin
        alu_src_A = 1'b1;
        alu_src_B = SRCB_IMM;
        alu_ctrl  = ALU_CTRL_RTYPE;
        state_d   = S_WB;
      end
      S_WB: begin
        reg_write = 1'b1;
        reg_dst   = wb_rtype_q;
        state_d   = S_FETCH;
      end
      S_MEMADDR: begin
        alu_src_A = 1'b1;
        alu_src_B = SRCB_IMM;
        state_d   = (opcode == OPC_W'(OPC_LW)) ? S_LWREAD : S_SWWRITE;
      end
      S_LWREAD: begin
        mem_read = 1'b1;
        I_or_D   = 1'b1;
        if (mem_ready) begin
          state_d = S_LWWB;
        end else if (wait_hit) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_LWWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_SWWRITE: begin
        mem_write = 1'b1;
        I_or_D    = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (wait_hit) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_TRAP: state_d = S_TRAP;
      // Unused encodings park in the trap state with no strobes asserted
      default: state_d = S_TRAP;
    endcase
  end

  // State and sticky flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_FETCH;
      wb_rtype_q <= 1'b0;
      illegal_q  <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wb_rtype_q <= wb_rtype_d;
      illegal_q  <= illegal_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign bus_err = bus_err_q;

`ifdef MULTICYCLE_RETIRE_CNT_EN
  logic [CNT_W-1:0] retired_q, retired_d;

  // An instruction retires on its last cycle, i.e. when re-entering fetch
  always_comb begin
    retired_d = retired_q;
    if ((state_d == S_FETCH) && (state_q != S_FETCH)) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  // Retire counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;
`else
  assign retired = '0;
`endif

endmodule
